// File: rtl/lcd_frame_reader_pkg.sv
// Shared widths and sequencer state encoding for the LCD frame reader.
package lcd_frame_reader_pkg;

   localparam int FIFO_W = 16;
   localparam int ADDR_W = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PREFILL = 2'd2,
      ACTIVE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/lcd_frame_reader.sv
// Frame-start reload of the double-buffered SDRAM read port, prefill wait, then one pop per active pixel.
// Pop-to-pixel latency 1 cycle; no backpressure: a pixel with nothing to pop (underrun or frame exhausted) is black.
module lcd_frame_reader
   import lcd_frame_reader_pkg::*;
#(
   parameter int                FIFO_WIDTH     = FIFO_W,
   parameter int                H_ACT          = 800,
   parameter int                V_ACT          = 480,
   parameter logic [ADDR_W-1:0] BUF0_BASE      = 24'h000000,
   parameter logic [ADDR_W-1:0] BUF1_BASE      = 24'h080000,
   parameter int                LOAD_CYCLES    = 4,
   parameter int                PREFILL_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sdram_init_done,
   input  logic                  lcd_vsync,
   input  logic                  lcd_de,
   input  logic                  wr_frame_done,
   input  logic                  wr_frame_buf,
   input  logic [FIFO_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic                  rd_load,
   output logic [ADDR_W-1:0]     rd_min_addr,
   output logic [ADDR_W-1:0]     rd_max_addr,
   output logic                  sdram_read_valid,
   output logic [FIFO_WIDTH-1:0] pix_data,
   output logic                  pix_de,
   output logic                  cur_buf,
   output logic                  err_underrun,
   output logic                  err_count
);

   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(H_ACT * V_ACT);
   localparam logic [9:0]        LOAD_LAST   = 10'(LOAD_CYCLES - 1);
   localparam logic [9:0]        PRE_LAST    = 10'(PREFILL_CYCLES - 1);

   rd_state_t           state, state_nx;
   logic                vsync_d;
   logic                vs_rise;
   logic                have_frame;
   logic                latest_buf;
   logic [9:0]          seq_cnt;
   logic [ADDR_W-1:0]   pix_cnt;
   logic                rd_en_d;
   logic                load_start;
   logic                pre_start;
   logic                frame_chk;
   logic                in_wait;
   logic [ADDR_W-1:0]   next_base;

   assign vs_rise   = lcd_vsync & ~vsync_d;
   assign in_wait   = (state == LOAD) || (state == PREFILL);
   assign next_base = latest_buf ? BUF1_BASE : BUF0_BASE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx         = state;
      load_start       = 1'b0;
      pre_start        = 1'b0;
      frame_chk        = 1'b0;
      rd_en            = 1'b0;
      rd_load          = 1'b0;
      sdram_read_valid = 1'b0;
      case (state)
         IDLE: begin
            if (vs_rise && sdram_init_done && have_frame) begin
               state_nx   = LOAD;
               load_start = 1'b1;
            end
         end
         LOAD: begin
            rd_load = 1'b1;
            if (seq_cnt == LOAD_LAST) begin
               state_nx  = PREFILL;
               pre_start = 1'b1;
            end
         end
         PREFILL: begin
            sdram_read_valid = 1'b1;
            if (seq_cnt == PRE_LAST) state_nx = ACTIVE;
         end
         ACTIVE: begin
            sdram_read_valid = 1'b1;
            rd_en            = lcd_de && (pix_cnt < FRAME_WORDS);
            if (!sdram_init_done) begin
               state_nx = IDLE;
            end else if (vs_rise) begin
               state_nx   = LOAD;
               load_start = 1'b1;
               frame_chk  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d      <= 1'b0;
         have_frame   <= 1'b0;
         latest_buf   <= 1'b0;
         cur_buf      <= 1'b0;
         rd_min_addr  <= '0;
         rd_max_addr  <= BUF0_BASE + FRAME_WORDS;
         seq_cnt      <= '0;
         pix_cnt      <= '0;
         rd_en_d      <= 1'b0;
         pix_de       <= 1'b0;
         err_underrun <= 1'b0;
         err_count    <= 1'b0;
      end else begin
         vsync_d <= lcd_vsync;
         rd_en_d <= rd_en;
         pix_de  <= lcd_de;

         // latest_buf is sampled by load_start before this cycle's update lands,
         // so a completion coinciding with frame start shows from the next frame
         if (wr_frame_done) begin
            latest_buf <= wr_frame_buf;
            have_frame <= 1'b1;
         end

         if (load_start) begin
            cur_buf     <= latest_buf;
            rd_min_addr <= next_base;
            rd_max_addr <= next_base + FRAME_WORDS;
         end

         if (load_start || pre_start) seq_cnt <= '0;
         else if (in_wait)            seq_cnt <= seq_cnt + 10'd1;

         if (pre_start)  pix_cnt <= '0;
         else if (rd_en) pix_cnt <= pix_cnt + 24'd1;

         if (frame_chk && (pix_cnt != FRAME_WORDS)) err_count <= 1'b1;
         if (lcd_de && in_wait)                     err_underrun <= 1'b1;
      end
   end

   // FIFO output is already registered; gate it with the delayed pop so idle pixels are black
   assign pix_data = rd_en_d ? rd_data : '0;

endmodule

// File: doc/lcd_frame_reader.md
# lcd_frame_reader

Read-side frame sequencer between the LCD timing generator and the SDRAM read port. It runs in the LCD pixel clock domain, which is the same clock as the read-port FIFO. At every frame start it reloads the read port with the newest fully written frame buffer (double-buffered) and waits for the read FIFO to prefill. It then pops one word per active pixel and presents registered pixel data aligned with a delayed data-enable.

## Interface
Parameters:
- FIFO_WIDTH, 16: read-port word width; one word per pixel.
- H_ACT, 800: active pixels per line.
- V_ACT, 480: active lines per frame.
- BUF0_BASE, 24'h000000: SDRAM word address of frame buffer 0.
- BUF1_BASE, 24'h080000: SDRAM word address of frame buffer 1.
- LOAD_CYCLES, 4: length of the rd_load pulse; range 1..15.
- PREFILL_CYCLES, 256: wait after load before the first pop; range 1..1023.
- Derived localparam FRAME_WORDS = H_ACT*V_ACT, held in 24 bits.

Ports:
- clk, in, 1: LCD pixel clock, the same clock as the read-port rd_clk.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- sdram_init_done, in, 1: SDRAM initialisation complete; level input.
- lcd_vsync, in, 1: frame sync, active-high; its rising edge marks frame start.
- lcd_de, in, 1: active-pixel enable from the timing generator.
- wr_frame_done, in, 1: one-cycle pulse from the write sequencer (already synchronous to clk) when a frame has been completely written.
- wr_frame_buf, in, 1: index of the buffer just completed; valid with wr_frame_done.
- rd_data, in, FIFO_WIDTH: read FIFO output, valid one cycle after rd_en.
- rd_en, out, 1: read FIFO pop.
- rd_load, out, 1: read-port reset; reloads the address and flushes the FIFO.
- rd_min_addr, out, 24: read start address.
- rd_max_addr, out, 24: read end address.
- sdram_read_valid, out, 1: enables SDRAM reads into the FIFO.
- pix_data, out, FIFO_WIDTH: pixel to the LCD.
- pix_de, out, 1: lcd_de delayed by one cycle.
- cur_buf, out, 1: buffer currently being displayed.
- err_underrun, out, 1: sticky error flag.
- err_count, out, 1: sticky error flag.

## Operation
- Reset values:
  - All outputs 0, except rd_max_addr = BUF0_BASE + FRAME_WORDS.
  - State IDLE; have_frame = 0; latest_buf = 0.
- Buffer latch:
  - When wr_frame_done is 1, latest_buf <= wr_frame_buf and have_frame <= 1.
  - Neither is ever cleared except by reset.
- Frame-start edge: vs_rise = lcd_vsync & ~vsync_d, where vsync_d is a registered copy of lcd_vsync.
- State machine:
  - IDLE:
    - rd_en = 0, sdram_read_valid = 0.
    - On vs_rise with sdram_init_done and have_frame both 1, go to LOAD.
  - LOAD:
    - rd_load = 1 for exactly LOAD_CYCLES cycles.
    - sdram_read_valid = 0.
    - On entry: cur_buf <= latest_buf; rd_min_addr <= base(latest_buf); rd_max_addr <= base + FRAME_WORDS.
    - Then go to PREFILL.
  - PREFILL:
    - sdram_read_valid = 1 (it stays 1 until the next LOAD).
    - Count PREFILL_CYCLES cycles, then go to ACTIVE.
    - Clear pix_cnt (24-bit) on entry.
  - ACTIVE:
    - rd_en = lcd_de & (pix_cnt < FRAME_WORDS).
    - pix_cnt increments on each rd_en.
    - On vs_rise, go to LOAD; err_count <= err_count | (pix_cnt != FRAME_WORDS).
    - If sdram_init_done falls, go to IDLE.
- Pixel output:
  - pix_de <= lcd_de.
  - pix_data <= rd_data when the previous cycle's rd_en was 1; otherwise 0 (black).
- Error conditions:
  - lcd_de = 1 while in LOAD or PREFILL sets err_underrun; no pop occurs.
  - lcd_de = 1 after pix_cnt reaches FRAME_WORDS: no pop, black pixel, no error.
- The address outputs change only on LOAD entry; they are stable at all other times.

## Timing
- Pop-to-pixel latency: 1 cycle. rd_en at cycle n gives pix_data at n+1, aligned with pix_de.
- Frame start: vs_rise at cycle n gives rd_load high for cycles n+1 .. n+LOAD_CYCLES. The first possible rd_en is at n+1+LOAD_CYCLES+PREFILL_CYCLES.
- wr_frame_done and vs_rise in the same cycle: the frame being loaded uses the old latest_buf; the new buffer shows from the following frame.
- vs_rise during LOAD or PREFILL: ignored; the sequence is not restarted.
- Async reset mid-frame: all outputs drop to reset values immediately; the block restarts in IDLE.

## Structure
- Shared package or include holds: FIFO_WIDTH, the state encoding (IDLE, LOAD, PREFILL, ACTIVE), and the 24-bit address width.
- Single module with no sub-modules; the vsync edge detector is inline.

## Test plan
1. Reset, then sdram_init_done = 1, no wr_frame_done, several vsyncs -> rd_load, rd_en and sdram_read_valid stay 0; pix_data = 0.
2. wr_frame_done with wr_frame_buf = 1, then vs_rise -> rd_load high for exactly 4 cycles; rd_min_addr = 24'h080000; rd_max_addr = 24'h080000 + 384000; cur_buf = 1.
3. Full frame with an FIFO model returning an incrementing count -> 384000 pops; pix_data matches the model 1 cycle after each rd_en; err_count stays 0.
4. lcd_de asserted 10 cycles after vs_rise (inside PREFILL) -> err_underrun = 1 and sticky; rd_en = 0 during PREFILL.
5. wr_frame_done (buffer 0) in the same cycle as vs_rise while buffer 1 is latest -> this frame shows cur_buf = 1; the next frame shows cur_buf = 0 with rd_min_addr = 0.
6. Short frame (383999 de cycles), then vs_rise -> err_count = 1. Reset asserted mid-ACTIVE -> all outputs 0 asynchronously and state IDLE.
